// File: rtl/axil_io_regs.sv
// AXI4-Lite slave exposing a small I/O register bank.
//   idx0           GPIO_OUT  RW, drives gpio_out directly
//   idx1           GPIO_IN   RO, gpio_in through a 2-flop synchronizer
//   idx2           CYCLE     RO, free-running cycle counter
//   idx3..N-1      SCRATCH   RW
// Ports:
//   aclk, areset_n          clock, asynchronous active-low reset
//   s_axil_io_aw*/w*/b*     AXI-Lite write address/data/response channels
//   s_axil_io_ar*/r*        AXI-Lite read address/data channels
//   gpio_in                 asynchronous external inputs
//   gpio_out                register 0 contents
module axil_io_regs #(
  parameter int unsigned C_S_AXIL_IO_ADDR_WIDTH = 32,
  parameter int unsigned C_S_AXIL_IO_DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS               = 8
) (
  input  logic                                aclk,
  input  logic                                areset_n,
  input  logic [C_S_AXIL_IO_ADDR_WIDTH-1:0]   s_axil_io_awaddr,
  input  logic [2:0]                          s_axil_io_awprot,
  input  logic                                s_axil_io_awvalid,
  output logic                                s_axil_io_awready,
  input  logic [C_S_AXIL_IO_DATA_WIDTH-1:0]   s_axil_io_wdata,
  input  logic [C_S_AXIL_IO_DATA_WIDTH/8-1:0] s_axil_io_wstrb,
  input  logic                                s_axil_io_wvalid,
  output logic                                s_axil_io_wready,
  output logic [1:0]                          s_axil_io_bresp,
  output logic                                s_axil_io_bvalid,
  input  logic                                s_axil_io_bready,
  input  logic [C_S_AXIL_IO_ADDR_WIDTH-1:0]   s_axil_io_araddr,
  input  logic [2:0]                          s_axil_io_arprot,
  input  logic                                s_axil_io_arvalid,
  output logic                                s_axil_io_arready,
  output logic [C_S_AXIL_IO_DATA_WIDTH-1:0]   s_axil_io_rdata,
  output logic [1:0]                          s_axil_io_rresp,
  output logic                                s_axil_io_rvalid,
  input  logic                                s_axil_io_rready,
  input  logic [C_S_AXIL_IO_DATA_WIDTH-1:0]   gpio_in,
  output logic [C_S_AXIL_IO_DATA_WIDTH-1:0]   gpio_out
);

  localparam int unsigned DW     = C_S_AXIL_IO_DATA_WIDTH;
  localparam int unsigned STRB_W = DW / 8;
  localparam int unsigned IDX_W  = $clog2(NUM_REGS);

  localparam logic [IDX_W-1:0] IDX_GPIO_IN = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_CYCLE   = IDX_W'(2);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  // Register bank; entries 1 and 2 are never written and read as their RO sources.
  logic [DW-1:0]    regs [NUM_REGS];
  logic [DW-1:0]    sync1, sync2;
  logic [DW-1:0]    cycle;

  // Write channel state
  wstate_t          wstate, wstate_n;
  logic             aw_held, aw_held_n;
  logic             w_held, w_held_n;
  logic [IDX_W-1:0] awidx_q, awidx_n;
  logic [DW-1:0]    wdata_q, wdata_n;
  logic [STRB_W-1:0] wstrb_q, wstrb_n;
  logic             awready_n, wready_n, bvalid_n;
  logic [1:0]       bresp_n;
  logic             commit_c;
  logic             wr_ok_c;

  // Read channel state
  rstate_t          rstate, rstate_n;
  logic             arready_n, rvalid_n;
  logic [1:0]       rresp_n;
  logic [DW-1:0]    rdata_n;
  logic [IDX_W-1:0] aridx_c;
  logic [DW-1:0]    rd_mux_c;

  logic             aw_hs_c, w_hs_c, ar_hs_c;

  // Address bits outside the index field and the prot signals carry no meaning here.
  logic             unused_c;
  assign unused_c = ^{s_axil_io_awprot, s_axil_io_arprot, s_axil_io_awaddr, s_axil_io_araddr};

  assign aw_hs_c = s_axil_io_awvalid && s_axil_io_awready;
  assign w_hs_c  = s_axil_io_wvalid && s_axil_io_wready;
  assign ar_hs_c = s_axil_io_arvalid && s_axil_io_arready;
  assign aridx_c = s_axil_io_araddr[IDX_W+1:2];
  assign wr_ok_c = (awidx_q != IDX_GPIO_IN) && (awidx_q != IDX_CYCLE);

  assign gpio_out = regs[0];

  // Input synchronizer and free-running cycle counter
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      cycle <= '0;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
      cycle <= cycle + DW'(1);
    end
  end

  // Register bank update on write commit, byte-lane masked
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit_c && wr_ok_c) begin
      for (int k = 0; k < STRB_W; k++) begin
        if (wstrb_q[k]) regs[awidx_q][8*k +: 8] <= wdata_q[8*k +: 8];
      end
    end
  end

  // Write FSM state register
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      wstate            <= W_IDLE;
      aw_held           <= 1'b0;
      w_held            <= 1'b0;
      awidx_q           <= '0;
      wdata_q           <= '0;
      wstrb_q           <= '0;
      s_axil_io_awready <= 1'b0;
      s_axil_io_wready  <= 1'b0;
      s_axil_io_bvalid  <= 1'b0;
      s_axil_io_bresp   <= RESP_OKAY;
    end else begin
      wstate            <= wstate_n;
      aw_held           <= aw_held_n;
      w_held            <= w_held_n;
      awidx_q           <= awidx_n;
      wdata_q           <= wdata_n;
      wstrb_q           <= wstrb_n;
      s_axil_io_awready <= awready_n;
      s_axil_io_wready  <= wready_n;
      s_axil_io_bvalid  <= bvalid_n;
      s_axil_io_bresp   <= bresp_n;
    end
  end

  // Write FSM next state; AW and W are captured independently, commit once both are held
  always_comb begin
    wstate_n  = wstate;
    aw_held_n = aw_held;
    w_held_n  = w_held;
    awidx_n   = awidx_q;
    wdata_n   = wdata_q;
    wstrb_n   = wstrb_q;
    awready_n = s_axil_io_awready;
    wready_n  = s_axil_io_wready;
    bvalid_n  = s_axil_io_bvalid;
    bresp_n   = s_axil_io_bresp;
    commit_c  = 1'b0;
    case (wstate)
      W_IDLE: begin
        if (aw_held && w_held) begin
          commit_c  = 1'b1;
          wstate_n  = W_RESP;
          aw_held_n = 1'b0;
          w_held_n  = 1'b0;
          bvalid_n  = 1'b1;
          bresp_n   = wr_ok_c ? RESP_OKAY : RESP_SLVERR;
          awready_n = 1'b0;
          wready_n  = 1'b0;
        end else begin
          if (aw_hs_c) begin
            aw_held_n = 1'b1;
            awidx_n   = s_axil_io_awaddr[IDX_W+1:2];
          end
          if (w_hs_c) begin
            w_held_n = 1'b1;
            wdata_n  = s_axil_io_wdata;
            wstrb_n  = s_axil_io_wstrb;
          end
          awready_n = !aw_held_n;
          wready_n  = !w_held_n;
        end
      end
      W_RESP: begin
        if (s_axil_io_bready) begin
          wstate_n  = W_IDLE;
          bvalid_n  = 1'b0;
          awready_n = 1'b1;
          wready_n  = 1'b1;
        end
      end
      default: wstate_n = W_IDLE;
    endcase
  end

  // Read source select; reflects register contents before any same-edge commit
  always_comb begin
    rd_mux_c = regs[aridx_c];
    if (aridx_c == IDX_GPIO_IN) rd_mux_c = sync2;
    if (aridx_c == IDX_CYCLE)   rd_mux_c = cycle;
  end

  // Read FSM state register
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      rstate            <= R_IDLE;
      s_axil_io_arready <= 1'b0;
      s_axil_io_rvalid  <= 1'b0;
      s_axil_io_rresp   <= RESP_OKAY;
      s_axil_io_rdata   <= '0;
    end else begin
      rstate            <= rstate_n;
      s_axil_io_arready <= arready_n;
      s_axil_io_rvalid  <= rvalid_n;
      s_axil_io_rresp   <= rresp_n;
      s_axil_io_rdata   <= rdata_n;
    end
  end

  // Read FSM next state
  always_comb begin
    rstate_n  = rstate;
    arready_n = s_axil_io_arready;
    rvalid_n  = s_axil_io_rvalid;
    rresp_n   = s_axil_io_rresp;
    rdata_n   = s_axil_io_rdata;
    case (rstate)
      R_IDLE: begin
        if (ar_hs_c) begin
          rstate_n  = R_DATA;
          arready_n = 1'b0;
          rvalid_n  = 1'b1;
          rresp_n   = RESP_OKAY;
          rdata_n   = rd_mux_c;
        end else begin
          arready_n = 1'b1;
        end
      end
      R_DATA: begin
        if (s_axil_io_rready) begin
          rstate_n  = R_IDLE;
          rvalid_n  = 1'b0;
          arready_n = 1'b1;
        end
      end
      default: rstate_n = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axil_io_regs.sv
// Directed, table-driven bench for axil_io_regs.
module tb_axil_io_regs;

  logic        aclk;
  logic        areset_n;
  logic [31:0] awaddr, wdata, araddr, rdata, gpio_in, gpio_out;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] ref_cyc;

  axil_io_regs #(
    .C_S_AXIL_IO_ADDR_WIDTH(32),
    .C_S_AXIL_IO_DATA_WIDTH(32),
    .NUM_REGS(8)
  ) dut (
    .aclk(aclk), .areset_n(areset_n),
    .s_axil_io_awaddr(awaddr), .s_axil_io_awprot(awprot),
    .s_axil_io_awvalid(awvalid), .s_axil_io_awready(awready),
    .s_axil_io_wdata(wdata), .s_axil_io_wstrb(wstrb),
    .s_axil_io_wvalid(wvalid), .s_axil_io_wready(wready),
    .s_axil_io_bresp(bresp), .s_axil_io_bvalid(bvalid), .s_axil_io_bready(bready),
    .s_axil_io_araddr(araddr), .s_axil_io_arprot(arprot),
    .s_axil_io_arvalid(arvalid), .s_axil_io_arready(arready),
    .s_axil_io_rdata(rdata), .s_axil_io_rresp(rresp),
    .s_axil_io_rvalid(rvalid), .s_axil_io_rready(rready),
    .gpio_in(gpio_in), .gpio_out(gpio_out)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Reference cycle count: edges since reset release
  always @(posedge aclk or negedge areset_n) begin
    if (!areset_n) ref_cyc <= '0;
    else           ref_cyc <= ref_cyc + 32'd1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (act=running req=finished)");
    $fatal(1);
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [14];

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: act=0x%08h req=0x%08h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp);
    int  n;
    logic aw_now, w_now;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    while ((awvalid || wvalid) && n < 50) begin
      aw_now = awvalid && awready;
      w_now  = wvalid && wready;
      tick();
      n++;
      if (aw_now) awvalid = 1'b0;
      if (w_now)  wvalid  = 1'b0;
    end
    while (!bvalid && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      chk("write_timeout", 32'(n), 32'd0);
      awvalid = 1'b0; wvalid = 1'b0;
    end
    resp = bresp;
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                         output logic [1:0] resp);
    int n;
    araddr = addr; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    while (!arready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("read_timeout", 32'(n), 32'd0);
    tick();
    arvalid = 1'b0;
    if (!rvalid) chk("read_rvalid", 32'(rvalid), 32'd1);
    data = rdata;
    resp = rresp;
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  initial begin
    logic [31:0] d, d0, d1, exp0;
    logic [1:0]  r;
    int          edges;
    logic        stable;

    tbl[0]  = '{1'b1, 32'h00, 32'hA5A5_1234, 4'hF, 2'b00, 32'h0};
    tbl[1]  = '{1'b0, 32'h00, 32'h0,         4'h0, 2'b00, 32'hA5A5_1234};
    tbl[2]  = '{1'b1, 32'h10, 32'h1122_3344, 4'hF, 2'b00, 32'h0};
    tbl[3]  = '{1'b1, 32'h10, 32'hAABB_CCDD, 4'h5, 2'b00, 32'h0};
    tbl[4]  = '{1'b0, 32'h10, 32'h0,         4'h0, 2'b00, 32'h11BB_33DD};
    tbl[5]  = '{1'b1, 32'h08, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0};
    tbl[6]  = '{1'b1, 32'h04, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0};
    tbl[7]  = '{1'b1, 32'h1C, 32'hDEAD_BEEF, 4'h0, 2'b00, 32'h0};
    tbl[8]  = '{1'b0, 32'h1C, 32'h0,         4'h0, 2'b00, 32'h0};
    tbl[9]  = '{1'b1, 32'h1C, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0};
    tbl[10] = '{1'b0, 32'h3C, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF};
    tbl[11] = '{1'b1, 32'h21, 32'h0000_FFFF, 4'hF, 2'b00, 32'h0};
    tbl[12] = '{1'b0, 32'h00, 32'h0,         4'h0, 2'b00, 32'h0000_FFFF};
    tbl[13] = '{1'b0, 32'h18, 32'h0,         4'h0, 2'b00, 32'h0};

    areset_n = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    gpio_in = '0;

    // Reset state
    tick(); tick();
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_bvalid",  32'(bvalid),  32'd0);
    chk("rst_gpio_out", gpio_out, 32'h0);
    areset_n = 1'b1;
    tick();
    chk("rel_awready", 32'(awready), 32'd1);
    chk("rel_wready",  32'(wready),  32'd1);
    chk("rel_arready", 32'(arready), 32'd1);

    // AW and W in the same cycle to idx0
    awaddr = 32'h0; wdata = 32'hA5A5_1234; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("s30_awready_held", 32'(awready), 32'd0);
    chk("s30_bvalid_early", 32'(bvalid), 32'd0);
    tick();
    chk("s30_bvalid", 32'(bvalid), 32'd1);
    chk("s30_bresp", 32'(bresp), 32'd0);
    chk("s30_gpio_out", gpio_out, 32'hA5A5_1234);
    tick();
    bready = 1'b0;
    chk("s30_bvalid_done", 32'(bvalid), 32'd0);
    chk("s30_awready_back", 32'(awready), 32'd1);

    // W first, AW three cycles later, single byte lane
    wdata = 32'hFFFF_FFFF; wstrb = 4'b0010; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("s31_wready_held", 32'(wready), 32'd0);
    chk("s31_awready_open", 32'(awready), 32'd1);
    tick(); tick();
    chk("s31_no_bvalid", 32'(bvalid), 32'd0);
    awaddr = 32'h0C; awvalid = 1'b1; bready = 1'b1;
    tick();
    awvalid = 1'b0;
    tick();
    chk("s31_bvalid", 32'(bvalid), 32'd1);
    chk("s31_bresp", 32'(bresp), 32'd0);
    tick();
    bready = 1'b0;
    do_read(32'h0C, d, r);
    chk("s31_readback", d, 32'h0000_FF00);

    // Read on the same edge as a commit to the same index sees the old value
    awaddr = 32'h14; wdata = 32'h77; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 32'h14; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    chk("s24_bvalid", 32'(bvalid), 32'd1);
    chk("s24_rvalid", 32'(rvalid), 32'd1);
    chk("s24_pre_write", rdata, 32'h0);
    rready = 1'b1;
    tick();
    rready = 1'b0; bready = 1'b0;
    do_read(32'h14, d, r);
    chk("s24_post_write", d, 32'h77);

    // Write to GPIO_IN is rejected; synchronized input reads back
    gpio_in = 32'h5A;
    do_write(32'h04, 32'h1234_5678, 4'hF, r);
    chk("s32_bresp", 32'(r), 32'd2);
    tick(); tick(); tick();
    do_read(32'h04, d, r);
    chk("s32_gpio_in", d, 32'h0000_005A);
    chk("s32_rresp", 32'(r), 32'd0);

    // Table-driven vectors
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].wr) begin
        do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, r);
        chk($sformatf("vec%0d_bresp", i), 32'(r), 32'(tbl[i].resp));
      end else begin
        do_read(tbl[i].addr, d, r);
        chk($sformatf("vec%0d_rdata", i), d, tbl[i].exp);
        chk($sformatf("vec%0d_rresp", i), 32'(r), 32'(tbl[i].resp));
      end
    end
    chk("tbl_gpio_out", gpio_out, 32'h0000_FFFF);

    // CYCLE read with rready stalled, then back-to-back CYCLE read
    araddr = 32'h08; arvalid = 1'b1; rready = 1'b0;
    tick();
    arvalid = 1'b0;
    exp0 = ref_cyc - 32'd1;
    d0 = rdata;
    chk("s33_cycle_value", d0, exp0);
    edges = 0;
    stable = 1'b1;
    repeat (5) begin
      tick();
      edges++;
      if (rvalid !== 1'b1 || rdata !== d0 || arready !== 1'b0) stable = 1'b0;
    end
    chk("s33_stall_stable", 32'(stable), 32'd1);
    rready = 1'b1;
    tick();
    edges++;
    rready = 1'b0;
    chk("s33_rvalid_drop", 32'(rvalid), 32'd0);
    chk("s33_arready_back", 32'(arready), 32'd1);
    arvalid = 1'b1;
    tick();
    edges++;
    arvalid = 1'b0;
    d1 = rdata;
    chk("s33_cycle_delta", d1 - d0, 32'(edges));
    rready = 1'b1;
    tick();
    rready = 1'b0;

    // Reset while a write response and a read response are pending
    awaddr = 32'h18; wdata = 32'h1; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 32'h00; arvalid = 1'b1; rready = 1'b0;
    tick();
    arvalid = 1'b0;
    chk("s34_bvalid_pending", 32'(bvalid), 32'd1);
    chk("s34_rvalid_pending", 32'(rvalid), 32'd1);
    #2;
    areset_n = 1'b0;
    #1;
    chk("s34_bvalid_async", 32'(bvalid), 32'd0);
    chk("s34_rvalid_async", 32'(rvalid), 32'd0);
    chk("s34_gpio_out", gpio_out, 32'h0);
    chk("s34_rdata", rdata, 32'h0);
    tick();
    chk("s34_awready_inrst", 32'(awready), 32'd0);
    areset_n = 1'b1;
    bready = 1'b1; rready = 1'b1;
    tick();
    chk("s34_awready_rel", 32'(awready), 32'd1);
    chk("s34_wready_rel", 32'(wready), 32'd1);
    chk("s34_arready_rel", 32'(arready), 32'd1);
    stable = 1'b1;
    repeat (4) begin
      tick();
      if (bvalid !== 1'b0 || rvalid !== 1'b0) stable = 1'b0;
    end
    chk("s34_no_stale", 32'(stable), 32'd1);
    bready = 1'b0; rready = 1'b0;
    do_read(32'h18, d, r);
    chk("s34_reg_cleared", d, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
